// File: rtl/icache_data_ctrl.sv
// Arbitrates the single-port I-cache data SRAM between fetch line reads and refill
// half-line writes, tracking the one partially filled line so it cannot be read early.
module icache_data_ctrl #(
    parameter int INDEX_W         = 6,
    parameter int LINE_W          = 128,
    parameter int FILL_STREAK_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_aL,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [INDEX_W-1:0]    rd_req_index,
    output logic                  rd_resp_valid,
    input  logic                  rd_resp_ready,
    output logic [LINE_W-1:0]     rd_resp_data,
    input  logic                  fill_valid,
    output logic                  fill_ready,
    input  logic [INDEX_W-1:0]    fill_index,
    input  logic                  fill_half,
    input  logic [LINE_W/2-1:0]   fill_data,
    output logic                  fill_done,
    output logic [INDEX_W-1:0]    fill_done_index,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [1:0]            sram_wmask0,
    output logic [INDEX_W-1:0]    sram_addr0,
    output logic [LINE_W-1:0]     sram_din0,
    input  logic [LINE_W-1:0]     sram_dout0
);
    localparam logic [3:0] STREAK_LIMIT = 4'(FILL_STREAK_MAX);

    function automatic logic [3:0] streak_sat_inc(input logic [3:0] s);
        return (s >= STREAK_LIMIT) ? STREAK_LIMIT : s + 4'd1;
    endfunction

    logic [1:0]         fmask;
    logic [INDEX_W-1:0] line_idx;
    logic [3:0]         streak;

    logic               hazard;
    logic               rd_ok;
    logic               fill_gnt;
    logic               rd_gnt;
    logic [1:0]         half_bit;
    logic [1:0]         fmask_merged;

    assign half_bit     = fill_half ? 2'b10 : 2'b01;
    assign fmask_merged = fmask | half_bit;

    // A read may only issue once the previous response is gone, so dout stays stable while valid.
    assign hazard   = (fmask != 2'b00) && (rd_req_index == line_idx);
    assign rd_ok    = rd_req_valid && !hazard && (!rd_resp_valid || rd_resp_ready);
    assign fill_gnt = rst_aL && fill_valid && !(rd_ok && (streak == STREAK_LIMIT));
    assign rd_gnt   = rst_aL && rd_ok && !fill_gnt;

    assign fill_ready   = fill_gnt;
    assign rd_req_ready = rd_gnt;
    assign rd_resp_data = sram_dout0;

    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = 2'b00;
        sram_addr0  = '0;
        sram_din0   = '0;
        if (rd_gnt) begin
            sram_csb0  = 1'b0;
            sram_addr0 = rd_req_index;
        end else if (fill_gnt) begin
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_wmask0 = half_bit;
            sram_addr0  = (fmask == 2'b00) ? fill_index : line_idx;
            sram_din0   = {fill_data, fill_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            fmask           <= 2'b00;
            line_idx        <= '0;
            streak          <= 4'd0;
            rd_resp_valid   <= 1'b0;
            fill_done       <= 1'b0;
            fill_done_index <= '0;
        end else begin
            fill_done <= 1'b0;
            if (fill_gnt) begin
                if (fmask == 2'b00)
                    line_idx <= fill_index;
                // Completion needs an earlier beat, so line_idx already names the line here.
                if (fmask_merged == 2'b11) begin
                    fmask           <= 2'b00;
                    fill_done       <= 1'b1;
                    fill_done_index <= line_idx;
                end else begin
                    fmask <= fmask_merged;
                end
            end

            if (rd_gnt || !rd_req_valid)
                streak <= 4'd0;
            else if (fill_gnt && rd_ok)
                streak <= streak_sat_inc(streak);

            if (rd_gnt)
                rd_resp_valid <= 1'b1;
            else if (rd_resp_ready)
                rd_resp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_icache_data_ctrl.sv
// Scoreboard bench for icache_data_ctrl: behavioural SRAM, line-level reference model,
// directed scenarios followed by randomized traffic with occasional resets.
module tb_icache_data_ctrl;
    localparam int INDEX_W = 6;
    localparam int LINE_W  = 128;
    localparam int HALF_W  = LINE_W / 2;
    localparam int SMAX    = 4;

    logic               clk = 1'b0;
    logic               rst_aL;
    logic               rd_req_valid;
    logic               rd_req_ready;
    logic [INDEX_W-1:0] rd_req_index;
    logic               rd_resp_valid;
    logic               rd_resp_ready;
    logic [LINE_W-1:0]  rd_resp_data;
    logic               fill_valid;
    logic               fill_ready;
    logic [INDEX_W-1:0] fill_index;
    logic               fill_half;
    logic [HALF_W-1:0]  fill_data;
    logic               fill_done;
    logic [INDEX_W-1:0] fill_done_index;
    logic               sram_csb0;
    logic               sram_web0;
    logic [1:0]         sram_wmask0;
    logic [INDEX_W-1:0] sram_addr0;
    logic [LINE_W-1:0]  sram_din0;
    logic [LINE_W-1:0]  sram_dout0;

    icache_data_ctrl #(.INDEX_W(INDEX_W), .LINE_W(LINE_W), .FILL_STREAK_MAX(SMAX)) dut (
        .clk(clk), .rst_aL(rst_aL),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_index(rd_req_index),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_index(fill_index),
        .fill_half(fill_half), .fill_data(fill_data),
        .fill_done(fill_done), .fill_done_index(fill_done_index),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural 1RW SRAM: inputs captured at posedge, memory/dout updated at the next negedge.
    logic [LINE_W-1:0]  smem [64];
    logic               s_en, s_we, s_clr;
    logic [1:0]         s_m;
    logic [INDEX_W-1:0] s_a;
    logic [LINE_W-1:0]  s_d;

    always @(posedge clk) begin
        s_en  <= !sram_csb0;
        s_we  <= !sram_web0;
        s_m   <= sram_wmask0;
        s_a   <= sram_addr0;
        s_d   <= sram_din0;
        s_clr <= !rst_aL;
    end

    always @(negedge clk) begin
        if (s_clr) begin
            for (int i = 0; i < 64; i++) smem[i] = '0;
            sram_dout0 <= '0;
        end else if (s_en) begin
            if (s_we) begin
                if (s_m[0]) smem[s_a][HALF_W-1:0]      = s_d[HALF_W-1:0];
                if (s_m[1]) smem[s_a][LINE_W-1:HALF_W] = s_d[LINE_W-1:HALF_W];
            end else begin
                sram_dout0 <= smem[s_a];
            end
        end
    end

    // Reference model state: the cache as whole lines, the one line being refilled, and the queues.
    typedef struct { logic [LINE_W-1:0] data; int gcyc; } rd_exp_t;
    typedef struct { int idx; int cyc; } done_exp_t;

    logic [LINE_W-1:0] ref_mem [64];
    rd_exp_t   exp_rd[$];
    done_exp_t exp_done[$];
    int        part_line = -1;
    bit        have_lo, have_hi;
    int        streak = 0;

    initial begin
        rd_exp_t   e;
        done_exp_t d;
        bit        free, blocked, want_rd, eg_fill, eg_rd;
        int        tgt;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_aL) begin
                check("rst_fill_ready", fill_ready, 1'b0);
                check("rst_rd_ready", rd_req_ready, 1'b0);
                check("rst_csb", sram_csb0, 1'b1);
                check("rst_web", sram_web0, 1'b1);
                for (int i = 0; i < 64; i++) ref_mem[i] = '0;
                exp_rd.delete();
                exp_done.delete();
                part_line = -1;
                have_lo = 0;
                have_hi = 0;
                streak = 0;
            end else begin
                free = (exp_rd.size() == 0) || rd_resp_ready;

                check("resp_valid", rd_resp_valid, exp_rd.size() != 0);
                if (rd_resp_valid && rd_resp_ready && exp_rd.size() != 0) begin
                    e = exp_rd.pop_front();
                    check("resp_data", rd_resp_data, e.data);
                end

                if (exp_done.size() != 0 && exp_done[0].cyc == cyc) begin
                    d = exp_done.pop_front();
                    check("fill_done", fill_done, 1'b1);
                    check("fill_done_index", fill_done_index, INDEX_W'(d.idx));
                end else begin
                    check("fill_done_quiet", fill_done, 1'b0);
                end

                blocked = (part_line >= 0) && (int'(rd_req_index) == part_line);
                want_rd = rd_req_valid && !blocked && free;
                eg_fill = fill_valid && !(want_rd && streak >= SMAX);
                eg_rd   = want_rd && !eg_fill;
                check("fill_ready", fill_ready, eg_fill);
                check("rd_req_ready", rd_req_ready, eg_rd);

                if (eg_rd) begin
                    check("rd_sram_csb", sram_csb0, 1'b0);
                    check("rd_sram_web", sram_web0, 1'b1);
                    check("rd_sram_addr", sram_addr0, rd_req_index);
                    e.data = ref_mem[rd_req_index];
                    e.gcyc = cyc;
                    exp_rd.push_back(e);
                end else if (eg_fill) begin
                    tgt = (part_line < 0) ? int'(fill_index) : part_line;
                    check("fill_sram_web", sram_web0, 1'b0);
                    check("fill_sram_addr", sram_addr0, INDEX_W'(tgt));
                    check("fill_sram_wmask", sram_wmask0, fill_half ? 2'b10 : 2'b01);
                    check("fill_sram_din", sram_din0, {fill_data, fill_data});
                    if (fill_half) begin
                        ref_mem[tgt][LINE_W-1:HALF_W] = fill_data;
                        have_hi = 1;
                    end else begin
                        ref_mem[tgt][HALF_W-1:0] = fill_data;
                        have_lo = 1;
                    end
                    if (have_lo && have_hi) begin
                        d.idx = tgt;
                        d.cyc = cyc + 1;
                        exp_done.push_back(d);
                        part_line = -1;
                        have_lo = 0;
                        have_hi = 0;
                    end else begin
                        part_line = tgt;
                    end
                end else begin
                    check("idle_csb", sram_csb0, 1'b1);
                end

                if (!rd_req_valid || eg_rd)
                    streak = 0;
                else if (eg_fill && want_rd)
                    streak++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input bit v, input int idx);
        rd_req_valid = v;
        rd_req_index = INDEX_W'(idx);
    endtask

    task automatic set_fill(input bit v, input int idx, input bit h, input logic [HALF_W-1:0] dat);
        fill_valid = v;
        fill_index = INDEX_W'(idx);
        fill_half  = h;
        fill_data  = dat;
    endtask

    task automatic quiet(input int n);
        set_rd(0, 0);
        set_fill(0, 0, 0, '0);
        rd_resp_ready = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        int  nf;
        bit  got, keep;
        rst_aL = 1'b0;
        rd_resp_ready = 1'b1;
        set_rd(0, 0);
        set_fill(0, 0, 0, '0);
        repeat (3) tick();
        rst_aL = 1'b1;
        tick();
        #6;
        check("rst_done_index", fill_done_index, '0);
        check("rst_resp_valid", rd_resp_valid, 1'b0);
        @(posedge clk);
        #1;

        // Two halves of line 5, then read it back as {B,A}.
        set_fill(1, 5, 0, 64'hAAAA_0000_1111_2222);
        tick();
        set_fill(1, 0, 1, 64'hBBBB_3333_4444_5555);
        tick();
        set_fill(0, 0, 0, '0);
        set_rd(1, 5);
        tick();
        quiet(3);

        // Line 9 half-filled: its read is held off, a read of line 10 slips through.
        set_fill(1, 9, 0, 64'h9999_0000_0000_0009);
        tick();
        set_fill(0, 0, 0, '0);
        set_rd(1, 9);
        repeat (2) tick();
        set_rd(1, 10);
        tick();
        set_rd(1, 9);
        set_fill(1, 33, 1, 64'h9999_1111_1111_1119);
        tick();
        set_fill(0, 0, 0, '0);
        repeat (2) tick();
        quiet(3);

        // Continuous refill against a waiting read of line 3.
        set_rd(1, 3);
        nf = 0;
        got = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            set_fill(1, 20, c[0], {$urandom, $urandom});
            #6;
            if (rd_req_ready) got = 1;
            else if (fill_ready) nf++;
            @(posedge clk);
            #1;
        end
        check("streak_fill_grants", nf, SMAX);
        check("streak_read_granted", got, 1'b1);
        quiet(3);

        // Back-to-back reads, then a stalled consumer.
        for (int i = 1; i <= 3; i++) begin
            set_rd(1, i);
            tick();
        end
        rd_resp_ready = 1'b0;
        set_rd(1, 4);
        tick();
        set_rd(1, 5);
        repeat (3) tick();
        rd_resp_ready = 1'b1;
        tick();
        quiet(3);

        // Duplicate upper half on line 7 before the lower half completes it.
        set_fill(1, 7, 1, 64'hD1D1_D1D1_D1D1_D1D1);
        tick();
        set_fill(1, 40, 1, 64'hD2D2_D2D2_D2D2_D2D2);
        tick();
        set_fill(1, 41, 0, 64'hE0E0_E0E0_E0E0_E0E0);
        tick();
        set_fill(0, 0, 0, '0);
        set_rd(1, 7);
        tick();
        quiet(3);

        // Reset in the middle of a line, then a fresh line elsewhere.
        set_fill(1, 12, 0, 64'h1212_1212_1212_1212);
        tick();
        set_fill(0, 0, 0, '0);
        rst_aL = 1'b0;
        tick();
        rst_aL = 1'b1;
        set_fill(1, 13, 1, 64'h1313_0000_0000_1313);
        tick();
        set_fill(1, 12, 0, 64'h1313_1111_1111_1313);
        tick();
        set_fill(0, 0, 0, '0);
        set_rd(1, 12);
        tick();
        set_rd(1, 13);
        tick();
        quiet(3);

        // Randomized traffic; read requests stay up until accepted.
        keep = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!keep) set_rd(($urandom % 3) != 0, $urandom_range(0, 15));
            set_fill(($urandom % 5) < 3, $urandom_range(0, 15), $urandom_range(0, 1), {$urandom, $urandom});
            rd_resp_ready = ($urandom % 4) != 0;
            rst_aL = ($urandom % 250) != 0;
            #6;
            keep = rd_req_valid && !rd_req_ready;
            @(posedge clk);
            #1;
        end
        rst_aL = 1'b1;
        quiet(6);
        check("drain_resp_queue", exp_rd.size(), 0);
        check("drain_done_queue", exp_done.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
